// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
package mem_arbiter_pkg;

    localparam int MemAddrBus  = 32;
    localparam int MemBusWidth = 32;

    // Lock ownership of the secondary slot.
    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbLock0 = 2'd1,
        ArbLock1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU, the two secondary masters, the RAM and the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = MemAddrBus,
    parameter int DW = MemBusWidth
) ();

    // CPU load/store port
    logic          cpu_read;
    logic          cpu_write;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;

    // Secondary master 0 (program loader)
    logic          m0_req;
    logic          m0_we;
    logic          m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    // Secondary master 1 (display/DMA)
    logic          m1_req;
    logic          m1_we;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    // RAM port (asynchronous read)
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_dout,
        output cpu_din,
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / RAM side
    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_dout,
        input  cpu_din,
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick with burst lock override and a blocking input
// (CPU cycle or reset) that suppresses every grant.
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       block_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);

    arb_state_e state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;

    // State and pointer registers; reset prefers master 0 with no lock held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next state: pointer moves past every granted master; lock follows the owner's lock bit.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt_o[0])      rr_ptr_d = 1'b1;
        else if (gnt_o[1]) rr_ptr_d = 1'b0;
        case (state_q)
            ArbIdle: begin
                if (gnt_o[0] && lock_i[0])      state_d = ArbLock0;
                else if (gnt_o[1] && lock_i[1]) state_d = ArbLock1;
            end
            ArbLock0: if (!req_i[0] || (gnt_o[0] && !lock_i[0])) state_d = ArbIdle;
            ArbLock1: if (!req_i[1] || (gnt_o[1] && !lock_i[1])) state_d = ArbIdle;
            default:  state_d = ArbIdle;
        endcase
    end

    // Grant: the lock owner only while locked, else a lone requester, else the pointer's pick.
    always_comb begin
        gnt_o = 2'b00;
        if (!block_i) begin
            case (state_q)
                ArbLock0: gnt_o[0] = req_i[0];
                ArbLock1: gnt_o[1] = req_i[1];
                default: begin
                    if (req_i == 2'b11) gnt_o[rr_ptr_q] = 1'b1;
                    else                gnt_o = req_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Data-memory arbiter: the CPU always owns the RAM when it strobes; the two
// secondary masters share the idle cycles and get a registered read response.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = MemAddrBus,
    parameter int DW = MemBusWidth
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic                cpu_active;
    logic [1:0]          req, lock, we, gnt;
    logic                mem_en_c, mem_we_c;
    logic [AW-1:0]       mem_addr_c;
    logic [DW-1:0]       mem_wdata_c;
    logic [1:0]          rvalid_q;
    logic [1:0][DW-1:0]  rdata_q;

    assign cpu_active = bus.cpu_read | bus.cpu_write;
    assign req        = {bus.m1_req,  bus.m0_req};
    assign lock       = {bus.m1_lock, bus.m0_lock};
    assign we         = {bus.m1_we,   bus.m0_we};

    mem_arbiter_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .block_i (cpu_active | rst),
        .req_i   (req),
        .lock_i  (lock),
        .gnt_o   (gnt)
    );

    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];

    // The CPU has no stall, so its strobes read the RAM in the same cycle.
    assign bus.cpu_din = bus.mem_rdata;

    // Memory port mux: CPU, then the granted master, else fully quiet (also during reset).
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (!rst && cpu_active) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.cpu_write;
            mem_addr_c  = bus.cpu_address;
            mem_wdata_c = bus.cpu_dout;
        end else if (gnt[0]) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.m0_we;
            mem_addr_c  = bus.m0_addr;
            mem_wdata_c = bus.m0_wdata;
        end else if (gnt[1]) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.m1_we;
            mem_addr_c  = bus.m1_addr;
            mem_wdata_c = bus.m1_wdata;
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    // Read response: capture RAM data on a granted read beat, rvalid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rvalid_q[k] <= gnt[k] & ~we[k];
                if (gnt[k] && !we[k]) rdata_q[k] <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single asynchronous-read data memory between the CPU load/store port and two secondary bus masters (program loader and display/DMA engine). The CPU has no stall input, so it always wins, with zero added latency. The secondary masters use a req/gnt handshake with round-robin fairness, optional burst lock and a registered read response. The block sits between `cpu` and the data RAM in the top level.

## Interface
- `AW`, default `MemAddrBus`: address width
- `DW`, default `MemBusWidth`: data width
- `clk`  in  1  clock
- `rst`  in  1  reset rst, synchronous, active-high; clock clk
- `cpu_read`, `cpu_write`  in  1  CPU requests (registered in the CPU)
- `cpu_address`  in  AW  CPU address
- `cpu_dout`  in  DW  CPU write data
- `cpu_din`  out  DW  CPU read data, combinational
- `mK_req`  in  1  master K request, K ∈ {0,1}
- `mK_we`  in  1  1 = write, 0 = read
- `mK_lock`  in  1  keep ownership after this beat
- `mK_addr`  in  AW  master K address
- `mK_wdata`  in  DW  master K write data
- `mK_gnt`  out  1  transfer accepted this cycle, combinational
- `mK_rvalid`  out  1  read data valid, registered
- `mK_rdata`  out  DW  read data, registered
- `mem_en`, `mem_we`  out  1  RAM enable and write strobe
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  DW  RAM write data
- `mem_rdata`  in  DW  RAM read data, same-cycle (asynchronous read)

## Operation
- **CPU slot.** `cpu_active = cpu_read | cpu_write`.
  - When active, the memory port is driven straight from the CPU: `mem_en=1`, `mem_we=cpu_write`, `mem_addr=cpu_address`, `mem_wdata=cpu_dout`.
  - Both strobes high is treated as a write.
  - `cpu_din = mem_rdata` at all times.
- **Secondary slot.** Used only when `cpu_active=0`. At most one `mK_gnt` is high per cycle, and never while `cpu_active=1`.
- **Winner selection, in order:**
  1. Lock owner, if it is requesting.
  2. If only one master requests, that master.
  3. If both request, the master selected by `rr_ptr`.
- **Transfer.** A transfer occurs on a cycle with `mK_req & mK_gnt`. The memory port carries master K's `we/addr/wdata`.
- **Handshake.** A master holds `req/we/addr/wdata/lock` stable until `gnt`. It may drop `req` at any time before `gnt`, with no side effect.
- **Round-robin.** On every granted beat, `rr_ptr <= 1-K`. Lock does not freeze `rr_ptr`.
- **Lock state machine.** States: `IDLE`, `LOCK0`, `LOCK1`.
  - `IDLE -> LOCKK`: granted beat with `mK_lock=1`.
  - `LOCKK -> IDLE`: granted beat with `mK_lock=0`, or any cycle with `mK_req=0`.
  - In `LOCKK`, the other master is never granted. CPU cycles still pre-empt master K; master K just sees `gnt=0`.
- **Read response.** On a granted read beat, `mK_rdata <= mem_rdata` and `mK_rvalid <= 1` for exactly one cycle. Otherwise `rvalid <= 0` and `rdata` holds its value.
- **Idle memory port.** When neither the CPU nor a secondary master is granted: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.

## Timing
- **Reset values:**
  - `rr_ptr=0` (m0 preferred), lock state `IDLE`.
  - `m0_rvalid=m1_rvalid=0`, `m0_rdata=m1_rdata=0`.
  - Combinational outputs follow their inputs; the memory-port outputs read 0 while `rst` is high.
- **Grant during reset.** All `gnt` are forced to 0 while `rst=1`. A beat presented during reset is not taken.
- **CPU path.** Zero cycles. A CPU `LW` issued at edge N captures `cpu_din` at edge N+1 unchanged.
- **Secondary write.** Commits at the edge ending the granted cycle.
- **Secondary read.** `rvalid`/`rdata` valid in the cycle after `gnt`.
- **Back-to-back.** One beat per cycle per master is possible. Back-to-back locked reads give `rvalid` on consecutive cycles.
- **No combinational loops.** `gnt` depends only on `req`, `lock`, the CPU strobes and internal state. Masters must not derive `req` combinationally from `gnt`.
- **Reset mid-lock / mid-read.** Returns to `IDLE`. A pending `rvalid` is cleared.

## Structure
- `MemAddrBus` and `MemBusWidth` come from `ArchDef.v`.
- New shared constants go in `ArchDef.v`: `ArbIdle=2'd0`, `ArbLock0=2'd1`, `ArbLock1=2'd2`.
- The natural sub-module is `rr_arb2`: a two-way round-robin pick with pointer and lock override, combinational pick plus pointer register.
- `mem_arbiter` contains the CPU override, memory mux and response registers.

## Test plan
- CPU `read=1`, `addr=0x10` (RAM[0x10]=0xDEADBEEF), m0 requesting the same cycle -> `cpu_din=0xDEADBEEF`, `m0_gnt=0`. m0 is granted the next CPU-idle cycle.
- m0 and m1 both reading continuously, CPU idle, 6 cycles after reset -> grants alternate m0,m1,m0,m1,m0,m1. Each `rvalid` arrives one cycle after its grant.
- m1 locked 4-beat write burst to 0x20–0x23 with m0 requesting throughout; CPU write inserted on beat 2 -> m1 gets 4 grants with a one-cycle gap, m0 is not granted until after the unlocked last beat, and RAM holds all 5 writes.
- m0 write 0x55 to 0x30, then m0 read 0x30 next cycle -> `m0_rvalid=1`, `m0_rdata=0x55` one cycle after the read grant.
- `rst` asserted while in `LOCK0` with `m0_rvalid` pending -> state `IDLE`, `rvalid=0`, `rr_ptr=0`. Both masters then requesting -> m0 is granted first.
- CPU `read` and `write` both high, `addr=0x40`, data 7 -> `mem_we=1`, and RAM[0x40]=7.
